ai_classify_scheduler: RTL



---
 rtl/ai_classify_scheduler_pkg.sv | 33 +++
 rtl/ai_classify_scheduler_if.sv | 22 ++
 rtl/ai_classify_scheduler_cls_vote_hist.sv | 51 +++++
 rtl/ai_classify_scheduler.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/ai_classify_scheduler_pkg.sv
// Shared types for the classification scheduler: waveform codes, confidence
// ceiling, FSM encoding and the history entry layout.
package ai_classify_scheduler_pkg;

    typedef enum logic [2:0] {
        WT_UNKNOWN  = 3'd0,
        WT_SINE     = 3'd1,
        WT_SQUARE   = 3'd2,
        WT_TRIANGLE = 3'd3,
        WT_SAWTOOTH = 3'd4,
        WT_NOISE    = 3'd5
    } wave_type_e;

    localparam logic [7:0] CONF_MAX = 8'd100;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_START    = 3'd1,
        ST_WAIT_CLS = 3'd2,
        ST_VOTE     = 3'd3,
        ST_HOLD     = 3'd4
    } state_e;

    typedef struct packed {
        logic [2:0] wtype;
        logic [7:0] conf;
    } hist_entry_t;

    function automatic logic [7:0] sat_conf(input logic [7:0] v);
        return (v > CONF_MAX) ? CONF_MAX : v;
    endfunction

endpackage

// File: rtl/ai_classify_scheduler_if.sv
// Classifier handshake plus voted result bus between the scheduler (master)
// and the extractor/classifier/UI side (slave).
interface ai_classify_scheduler_if;
    logic       feat_start;
    logic [2:0] cls_type;
    logic [7:0] cls_conf;
    logic       cls_valid;
    logic [2:0] stable_type;
    logic [7:0] stable_conf;
    logic       stable_valid;
    logic       stable_changed;

    modport master (
        output feat_start, stable_type, stable_conf, stable_valid, stable_changed,
        input  cls_type, cls_conf, cls_valid
    );

    modport slave (
        input  feat_start, stable_type, stable_conf, stable_valid, stable_changed,
        output cls_type, cls_conf, cls_valid
    );
endinterface

// File: rtl/ai_classify_scheduler_cls_vote_hist.sv
// Shift-register history of classifier results; reports how many entries
// agree with the newest type and the summed confidence of those entries.
module cls_vote_hist
    import ai_classify_scheduler_pkg::*;
#(
    parameter int  HIST_DEPTH = 4,
    localparam int LOG2_D     = $clog2(HIST_DEPTH),
    localparam int CNT_W      = $clog2(HIST_DEPTH + 1),
    localparam int SUM_W      = 8 + LOG2_D
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  hist_entry_t       push_entry,
    output logic [2:0]        newest_type,
    output logic [CNT_W-1:0]  match_cnt,
    output logic [SUM_W-1:0]  match_sum
);

    hist_entry_t [HIST_DEPTH-1:0] hist_q, hist_d;
    logic [HIST_DEPTH-1:0]        match;

    // Entry 0 is the newest; the oldest falls off the top on every push.
    always_comb begin
        hist_d = hist_q;
        if (push) hist_d = {hist_q[HIST_DEPTH-2:0], push_entry};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) hist_q <= '0;
        else        hist_q <= hist_d;
    end

    for (genvar g = 0; g < HIST_DEPTH; g++) begin : g_match
        assign match[g] = (hist_q[g].wtype == hist_q[0].wtype);
    end

    always_comb begin
        match_cnt = '0;
        match_sum = '0;
        for (int i = 0; i < HIST_DEPTH; i++) begin
            if (match[i]) begin
                match_cnt = match_cnt + CNT_W'(1);
                match_sum = match_sum + SUM_W'(hist_q[i].conf);
            end
        end
    end

    assign newest_type = hist_q[0].wtype;

endmodule

// File: rtl/ai_classify_scheduler.sv
// Launches feature-extraction runs, waits (with timeout) for the classifier
// and majority-votes the recent results into a stable type/confidence.
module ai_classify_scheduler
    import ai_classify_scheduler_pkg::*;
#(
    parameter int HIST_DEPTH  = 4,
    parameter int VOTE_MIN    = 3,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        single_shot,
    input  logic [23:0] interval,
    input  logic        clear_err,
    output logic        busy,
    output logic        timeout_err,
    ai_classify_scheduler_if.master bus
);

    localparam int LOG2_D = $clog2(HIST_DEPTH);
    localparam int CNT_W  = $clog2(HIST_DEPTH + 1);
    localparam int SUM_W  = 8 + LOG2_D;
    localparam int TO_W   = $clog2(TIMEOUT_CYC + 1);
    localparam int CTR_W  = (TO_W > 24) ? TO_W : 24;

    localparam logic [CTR_W-1:0] TO_LAST    = CTR_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] VOTE_MIN_C = CNT_W'(VOTE_MIN);

    state_e             state_q, state_d;
    logic [CTR_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         stable_type_q, stable_type_d;
    logic [7:0]         stable_conf_q, stable_conf_d;
    logic               stable_valid_q, stable_valid_d;
    logic               stable_changed_q, stable_changed_d;
    logic               timeout_err_q, timeout_err_d;

    logic               push;
    hist_entry_t        push_entry;
    logic [2:0]         newest_type;
    logic [CNT_W-1:0]   match_cnt;
    logic [SUM_W-1:0]   match_sum;
    logic [7:0]         conf_avg;
    logic               unused_sum_lsb;
    logic [CTR_W-1:0]   hold_len;

    cls_vote_hist #(.HIST_DEPTH(HIST_DEPTH)) u_hist (
        .clk         (clk),
        .rst_n       (rst_n),
        .push        (push),
        .push_entry  (push_entry),
        .newest_type (newest_type),
        .match_cnt   (match_cnt),
        .match_sum   (match_sum)
    );

    // Dropping the low bits divides the matching sum by the full depth, so
    // disagreeing entries pull the confidence down.
    assign conf_avg       = match_sum[SUM_W-1:LOG2_D];
    assign unused_sum_lsb = ^match_sum[LOG2_D-1:0];
    assign hold_len       = (interval == '0) ? CTR_W'(1) : CTR_W'(interval);

    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        push             = 1'b0;
        push_entry       = '0;
        stable_type_d    = stable_type_q;
        stable_conf_d    = stable_conf_q;
        stable_valid_d   = 1'b0;
        stable_changed_d = 1'b0;
        timeout_err_d    = clear_err ? 1'b0 : timeout_err_q;

        case (state_q)
            ST_IDLE: begin
                if (enable || single_shot) state_d = ST_START;
            end
            ST_START: begin
                cnt_d   = '0;
                state_d = ST_WAIT_CLS;
            end
            ST_WAIT_CLS: begin
                if (bus.cls_valid) begin
                    push       = 1'b1;
                    push_entry = '{wtype: bus.cls_type, conf: bus.cls_conf};
                    state_d    = ST_VOTE;
                end else if (cnt_q == TO_LAST) begin
                    // A missing result counts as an unknown vote; set beats clear.
                    push          = 1'b1;
                    timeout_err_d = 1'b1;
                    state_d       = ST_VOTE;
                end else begin
                    cnt_d = cnt_q + CTR_W'(1);
                end
            end
            ST_VOTE: begin
                if (match_cnt >= VOTE_MIN_C && newest_type != WT_UNKNOWN) begin
                    stable_type_d    = newest_type;
                    stable_conf_d    = sat_conf(conf_avg);
                    stable_changed_d = (newest_type != stable_type_q);
                end
                stable_valid_d = 1'b1;
                cnt_d          = '0;
                state_d        = ST_HOLD;
            end
            ST_HOLD: begin
                if ((cnt_q + CTR_W'(1)) >= hold_len) state_d = enable ? ST_START : ST_IDLE;
                else                                 cnt_d   = cnt_q + CTR_W'(1);
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q          <= ST_IDLE;
            cnt_q            <= '0;
            stable_type_q    <= '0;
            stable_conf_q    <= '0;
            stable_valid_q   <= 1'b0;
            stable_changed_q <= 1'b0;
            timeout_err_q    <= 1'b0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            stable_type_q    <= stable_type_d;
            stable_conf_q    <= stable_conf_d;
            stable_valid_q   <= stable_valid_d;
            stable_changed_q <= stable_changed_d;
            timeout_err_q    <= timeout_err_d;
        end
    end

    assign bus.feat_start     = (state_q == ST_START);
    assign bus.stable_type    = stable_type_q;
    assign bus.stable_conf    = stable_conf_q;
    assign bus.stable_valid   = stable_valid_q;
    assign bus.stable_changed = stable_changed_q;
    assign busy               = (state_q != ST_IDLE);
    assign timeout_err        = timeout_err_q;

endmodule
